// File: rtl/pan_tilt_stepper_pkg.sv
// Shared types and default timing for the pan/tilt stepper block.
package pan_tilt_stepper_pkg;

    typedef enum logic [1:0] {StIdle, StSetup, StPulse, StGap} axis_state_e;

    localparam int unsigned XPosW = 8;
    localparam int unsigned YPosW = 7;
    localparam int unsigned CntW  = 16;

    localparam int unsigned DefStepDiv  = 1000;
    localparam int unsigned DefPulseW   = 100;
    localparam int unsigned DefDirSetup = 50;
    localparam int unsigned DefXHome    = 128;
    localparam int unsigned DefYHome    = 64;

endpackage

// File: rtl/pan_tilt_stepper_if.sv
// Command fields in, step/dir drive and position status out.
interface pan_tilt_stepper_if;
    import pan_tilt_stepper_pkg::*;

    logic             cmd_valid;
    logic [XPosW-1:0] x_target;
    logic [YPosW-1:0] y_target;
    logic             cmd_enable;
    logic             step_x;
    logic             dir_x;
    logic             step_y;
    logic             dir_y;
    logic [XPosW-1:0] x_pos;
    logic [YPosW-1:0] y_pos;
    logic             busy;

    modport master (
        output cmd_valid, x_target, y_target, cmd_enable,
        input  step_x, dir_x, step_y, dir_y, x_pos, y_pos, busy
    );

    modport slave (
        input  cmd_valid, x_target, y_target, cmd_enable,
        output step_x, dir_x, step_y, dir_y, x_pos, y_pos, busy
    );

endinterface

// File: rtl/pan_tilt_stepper_axis.sv
// One stepper axis: walks pos toward tgt with paced step pulses and a dir setup window.
module pan_tilt_stepper_axis
    import pan_tilt_stepper_pkg::*;
#(
    parameter int unsigned       POS_W     = 8,
    parameter logic [POS_W-1:0]  HOME      = '0,
    parameter int unsigned       STEP_DIV  = DefStepDiv,
    parameter int unsigned       PULSE_W   = DefPulseW,
    parameter int unsigned       DIR_SETUP = DefDirSetup
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [POS_W-1:0] tgt,
    input  logic             enable,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             active
);

    // Terminal counts; each timed state lasts (last + 1) cycles.
    localparam logic [CntW-1:0]  SetupLast = CntW'(DIR_SETUP - 1);
    localparam logic [CntW-1:0]  PulseLast = CntW'(PULSE_W - 1);
    localparam logic [CntW-1:0]  GapLast   = CntW'(STEP_DIV - PULSE_W - 1);
    localparam logic [POS_W-1:0] PosOne    = POS_W'(1);

    axis_state_e      state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [POS_W-1:0] pos_q, pos_d, tgt_q;
    logic             en_q, dir_q, dir_d, step_q, step_d;
    logic             need_move, need_dir;

    // Decisions see a registered copy of target/enable, keeping the compare off the latch path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_q <= HOME;
            en_q  <= 1'b1;
        end else begin
            tgt_q <= tgt;
            en_q  <= enable;
        end
    end

    assign need_move = en_q && (tgt_q != pos_q);
    assign need_dir  = tgt_q > pos_q;

    // Axis state, cycle counter, position and step/dir registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pos_q   <= HOME;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
        end
    end

    // Next-state: IDLE and end of GAP are the only points where target/enable are consulted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CntW'(1);
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = step_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (need_move) begin
                    dir_d   = need_dir;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    step_d  = 1'b1;
                    state_d = StPulse;
                end
            end
            StPulse: begin
                if (cnt_q == PulseLast) begin
                    cnt_d   = '0;
                    step_d  = 1'b0;
                    pos_d   = dir_q ? pos_q + PosOne : pos_q - PosOne;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d = '0;
                    if (!need_move) begin
                        state_d = StIdle;
                    end else if (need_dir == dir_q) begin
                        step_d  = 1'b1;
                        state_d = StPulse;
                    end else begin
                        dir_d   = need_dir;
                        state_d = StSetup;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign step   = step_q;
    assign dir    = dir_q;
    assign pos    = pos_q;
    assign active = (state_q != StIdle);

endmodule

// File: rtl/pan_tilt_stepper.sv
// Pan/tilt stepper controller: latches absolute targets and drives two independent axes.
module pan_tilt_stepper
    import pan_tilt_stepper_pkg::*;
#(
    parameter int unsigned STEP_DIV  = DefStepDiv,
    parameter int unsigned PULSE_W   = DefPulseW,
    parameter int unsigned DIR_SETUP = DefDirSetup,
    parameter int unsigned X_HOME    = DefXHome,
    parameter int unsigned Y_HOME    = DefYHome
) (
    input logic               clk,
    input logic               reset,
    pan_tilt_stepper_if.slave bus
);

    logic [XPosW-1:0] x_tgt_q;
    logic [YPosW-1:0] y_tgt_q;
    logic             enable_q, busy_q;
    logic             x_active, y_active;

    // Command latch: enable always follows the command, targets only when it is enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_tgt_q  <= XPosW'(X_HOME);
            y_tgt_q  <= YPosW'(Y_HOME);
            enable_q <= 1'b1;
        end else if (bus.cmd_valid) begin
            enable_q <= bus.cmd_enable;
            if (bus.cmd_enable) begin
                x_tgt_q <= bus.x_target;
                y_tgt_q <= bus.y_target;
            end
        end
    end

    // Busy is a registered OR of both axes being out of IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= x_active | y_active;
        end
    end

    pan_tilt_stepper_axis #(
        .POS_W     (XPosW),
        .HOME      (XPosW'(X_HOME)),
        .STEP_DIV  (STEP_DIV),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP)
    ) u_pan (
        .clk    (clk),
        .reset  (reset),
        .tgt    (x_tgt_q),
        .enable (enable_q),
        .step   (bus.step_x),
        .dir    (bus.dir_x),
        .pos    (bus.x_pos),
        .active (x_active)
    );

    pan_tilt_stepper_axis #(
        .POS_W     (YPosW),
        .HOME      (YPosW'(Y_HOME)),
        .STEP_DIV  (STEP_DIV),
        .PULSE_W   (PULSE_W),
        .DIR_SETUP (DIR_SETUP)
    ) u_tilt (
        .clk    (clk),
        .reset  (reset),
        .tgt    (y_tgt_q),
        .enable (enable_q),
        .step   (bus.step_y),
        .dir    (bus.dir_y),
        .pos    (bus.y_pos),
        .active (y_active)
    );

    assign bus.busy = busy_q;

endmodule
